// File: rtl/dcm_prog_pkg.sv
// Shared definitions for the DCM_CLKGEN M/D reprogramming controller:
// FSM encodings, PROGDATA command codes (LSB first) and error codes.
package dcm_prog_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP_D,
    ST_LOAD_M,
    ST_GAP_M,
    ST_GO,
    ST_WAIT_DONE,
    ST_WAIT_LOCK,
    ST_RECOVER
  } state_e;

  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_M = 2'd1;
  localparam logic [1:0] ERR_DONE_TO   = 2'd2;
  localparam logic [1:0] ERR_LOCK_TO   = 2'd3;

  localparam int unsigned GAP_CYCLES = 2;

  // Command bits occupy the low end so they leave the shifter first.
  function automatic logic [9:0] prog_word(input logic [1:0] cmd, input logic [7:0] val);
    return {val, cmd};
  endfunction

endpackage

// File: rtl/dcm_prog_shifter.sv
// 10-bit LSB-first serialiser feeding DCM PROGDATA; last flags the tenth bit.
module dcm_prog_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [9:0] load_word,
  output logic       sout,
  output logic       last
);

  logic [9:0] sreg_q, sreg_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = load_word;
      cnt_d  = 4'd0;
    end else if (shift) begin
      sreg_d = {1'b0, sreg_q[9:1]};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sout = sreg_q[0];
  assign last = (cnt_q == 4'd9);

endmodule

// File: rtl/dcm_prog_ctrl.sv
// DCM_CLKGEN runtime M/D reprogramming controller: serialises LoadD, LoadM and GO,
// waits for PROGDONE and LOCKED, and gates the 25 MHz output enable meanwhile.
module dcm_prog_ctrl
  import dcm_prog_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned RST_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_mul_m1,
  input  logic [7:0] cfg_div_m1,
  input  logic       clk_on_req,
  output logic       clk25m_on,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       prog_en,
  output logic       prog_data,
  output logic       dcm_rst,
  input  logic       prog_done,
  input  logic       dcm_locked
);

  localparam logic [15:0] DONE_LAST = 16'(DONE_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  mul_q, mul_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        clk_on_q, clk_on_d;
  logic        lock_meta_q, lock_sync_q;

  logic        sh_load, sh_shift, sh_sout, sh_last;
  logic [9:0]  sh_word;

  dcm_prog_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_word (sh_word),
    .sout      (sh_sout),
    .last      (sh_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_d      = mul_q;
    div_d      = div_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_word    = prog_word(CMD_LOAD_D, div_q);

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_mul_m1 == 8'd0) begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL_M;
          end else begin
            mul_d      = cfg_mul_m1;
            div_d      = cfg_div_m1;
            err_code_d = ERR_NONE;
            sh_load    = 1'b1;
            sh_word    = prog_word(CMD_LOAD_D, cfg_div_m1);
            state_d    = ST_LOAD_D;
          end
        end
      end
      ST_LOAD_D: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          state_d = ST_GAP_D;
          cnt_d   = '0;
        end
      end
      ST_GAP_D: begin
        if (cnt_q == GAP_LAST) begin
          sh_load = 1'b1;
          sh_word = prog_word(CMD_LOAD_M, mul_q);
          state_d = ST_LOAD_M;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LOAD_M: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          state_d = ST_GAP_M;
          cnt_d   = '0;
        end
      end
      ST_GAP_M: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_GO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GO: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = '0;
      end
      ST_WAIT_DONE: begin
        if (prog_done) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == DONE_LAST) begin
          state_d    = ST_RECOVER;
          cnt_d      = '0;
          err_code_d = ERR_DONE_TO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d    = ST_RECOVER;
          cnt_d      = '0;
          err_code_d = ERR_LOCK_TO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RECOVER: begin
        // The DCM comes back at its bitstream defaults; the host must re-request.
        if (cnt_q == RST_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clk_on_d = clk_on_req & lock_sync_q & (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mul_q       <= '0;
      div_q       <= '0;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clk_on_q    <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_q       <= mul_d;
      div_q       <= div_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      err_q       <= err_d;
      clk_on_q    <= clk_on_d;
      lock_meta_q <= dcm_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign clk25m_on = clk_on_q;
  assign dcm_rst   = (state_q == ST_RECOVER);
  assign prog_en   = (state_q == ST_LOAD_D) | (state_q == ST_LOAD_M) | (state_q == ST_GO);
  assign prog_data = ((state_q == ST_LOAD_D) | (state_q == ST_LOAD_M)) & sh_sout;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a behavioural DCM model and a queue of
// expected PROGEN/PROGDATA pairs per programming sequence.
module tb_dcm_prog_ctrl;

  localparam int DONE_TIMEOUT = 4096;
  localparam int RST_CYCLES   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_mul_m1 = 8'd0;
  logic [7:0] cfg_div_m1 = 8'd0;
  logic       clk_on_req = 1'b0;
  logic       clk25m_on, busy, done, err;
  logic [1:0] err_code;
  logic       prog_en, prog_data, dcm_rst;
  logic       prog_done = 1'b0;
  logic       dcm_locked;
  logic       model_locked = 1'b1;
  logic       force_unlock = 1'b0;
  logic       respond = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;
  logic [1:0] exp_q[$];

  assign dcm_locked = model_locked & ~force_unlock;

  always #5 clk = ~clk;

  dcm_prog_ctrl #(
    .DONE_TIMEOUT (DONE_TIMEOUT),
    .LOCK_TIMEOUT (65535),
    .RST_CYCLES   (RST_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mul_m1 (cfg_mul_m1),
    .cfg_div_m1 (cfg_div_m1),
    .clk_on_req (clk_on_req),
    .clk25m_on  (clk25m_on),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .prog_en    (prog_en),
    .prog_data  (prog_data),
    .dcm_rst    (dcm_rst),
    .prog_done  (prog_done),
    .dcm_locked (dcm_locked)
  );

  // DCM model: PROGDONE 5 cycles after GO, LOCKED 100 cycles after that,
  // LOCKED back 11 cycles after a DCM reset.
  initial begin : dcm_model
    int   done_cnt;
    int   lock_cnt;
    logic prev_en;
    logic go;
    done_cnt = -1;
    lock_cnt = -1;
    prev_en  = 1'b0;
    forever begin
      @(posedge clk); #1;
      go        = prog_en & ~prev_en & ~prog_data;
      prev_en   = prog_en;
      prog_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          prog_done = 1'b1;
          lock_cnt  = 100;
          done_cnt  = -1;
        end
      end
      if (lock_cnt > 0) begin
        lock_cnt--;
        if (lock_cnt == 0) begin
          model_locked = 1'b1;
          lock_cnt     = -1;
        end
      end
      if (go) begin
        model_locked = 1'b0;
        done_cnt     = respond ? 5 : -1;
      end
      if (dcm_rst) begin
        model_locked = 1'b0;
        done_cnt     = -1;
        lock_cnt     = 11;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [7:0] mul, input logic [7:0] div);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, div[i]});
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, mul[i]});
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  task automatic start_req(input logic [7:0] mul, input logic [7:0] div);
    cfg_mul_m1 = mul;
    cfg_div_m1 = div;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  // intr_at >= 0 raises a competing request for 5 cycles starting at that stream index.
  task automatic run_stream(input int intr_at);
    logic [1:0] e;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) tick();
      if (k == intr_at) begin
        cfg_mul_m1 = 8'h55;
        cfg_div_m1 = 8'h22;
        cfg_valid  = 1'b1;
      end
      if (k == intr_at + 5) cfg_valid = 1'b0;
      if (exp_q.size() == 0) begin
        check("stream_underflow", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("stream[%0d]", k), {14'd0, prog_en, prog_data}, {14'd0, e});
      end
    end
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && err !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("done_seen", {15'd0, done}, 16'd1);
    check("err_with_done", {15'd0, err}, 16'd0);
    check("busy_after_done", {15'd0, busy}, 16'd0);
    check("err_code_after_done", {14'd0, err_code}, 16'd0);
    tick();
    check("done_one_cycle", {15'd0, done}, 16'd0);
  endtask

  initial begin : stimulus
    int cnt;
    int seen;
    clk_on_req = 1'b1;
    #12;
    check("rst_prog_en", {15'd0, prog_en}, 16'd0);
    check("rst_prog_data", {15'd0, prog_data}, 16'd0);
    check("rst_dcm_rst", {15'd0, dcm_rst}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_err_code", {14'd0, err_code}, 16'd0);
    check("rst_clk25m_on", {15'd0, clk25m_on}, 16'd0);
    check("rst_cfg_ready", {15'd0, cfg_ready}, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    check("clk_on_idle", {15'd0, clk25m_on}, 16'd1);

    // M=4, D=1
    push_stream(8'd3, 8'd0);
    start_req(8'd3, 8'd0);
    check("busy_after_accept", {15'd0, busy}, 16'd1);
    check("ready_low_busy", {15'd0, cfg_ready}, 16'd0);
    run_stream(-100);
    tick();
    check("clk_off_busy", {15'd0, clk25m_on}, 16'd0);
    wait_done();
    check("clk_on_restored", {15'd0, clk25m_on}, 16'd1);

    // Illegal M
    start_req(8'd0, 8'd5);
    check("illegal_err", {15'd0, err}, 16'd1);
    check("illegal_err_code", {14'd0, err_code}, 16'd1);
    check("illegal_ready", {15'd0, cfg_ready}, 16'd1);
    check("illegal_busy", {15'd0, busy}, 16'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (prog_en === 1'b1) seen++;
      tick();
    end
    check("illegal_no_prog_en", 16'(seen), 16'd0);
    check("illegal_err_code_held", {14'd0, err_code}, 16'd1);

    // Competing request during LOAD_M
    push_stream(8'h07, 8'h02);
    start_req(8'h07, 8'h02);
    run_stream(14);
    wait_done();
    seen = 0;
    cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      if (prog_en === 1'b1) seen++;
      if (done === 1'b1) cnt++;
      tick();
    end
    check("no_second_sequence", 16'(seen), 16'd0);
    check("no_second_done", 16'(cnt), 16'd0);

    // PROGDONE never arrives
    respond = 1'b0;
    push_stream(8'h09, 8'h03);
    start_req(8'h09, 8'h03);
    run_stream(-100);
    cnt = 0;
    while (dcm_rst !== 1'b1 && cnt < 6000) begin
      tick();
      cnt++;
    end
    check("done_timeout_cycles", 16'(cnt), 16'(DONE_TIMEOUT + 1));
    check("err_code_recover", {14'd0, err_code}, 16'd2);
    cnt = 1;
    tick();
    while (dcm_rst === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
    check("rst_cycles", 16'(cnt), 16'(RST_CYCLES));
    check("timeout_err", {15'd0, err}, 16'd1);
    check("timeout_done_low", {15'd0, done}, 16'd0);
    check("timeout_err_code", {14'd0, err_code}, 16'd2);
    check("timeout_idle", {15'd0, cfg_ready}, 16'd1);
    respond = 1'b1;
    repeat (20) tick();

    // Reset mid-LOAD_D
    start_req(8'h04, 8'h04);
    repeat (3) tick();
    check("pre_rst_prog_en", {15'd0, prog_en}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_prog_en", {15'd0, prog_en}, 16'd0);
    check("async_rst_busy", {15'd0, busy}, 16'd0);
    check("async_rst_ready", {15'd0, cfg_ready}, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    push_stream(8'h1f, 8'ha5);
    start_req(8'h1f, 8'ha5);
    run_stream(-100);
    wait_done();

    // Loss of lock in IDLE
    repeat (3) tick();
    check("clk_on_before_unlock", {15'd0, clk25m_on}, 16'd1);
    force_unlock = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (clk25m_on === 1'b0) seen = 1;
    end
    check("unlock_clk_off", 16'(seen), 16'd1);
    check("unlock_no_busy", {15'd0, busy}, 16'd0);
    check("unlock_no_err", {15'd0, err}, 16'd0);
    force_unlock = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (clk25m_on === 1'b1) seen = 1;
    end
    check("relock_clk_on", 16'(seen), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
